// File: rtl/secuenciador_registros_rtc_pkg.sv
// Shared register indices, FSM encoding and sequence table for the RTC register sequencer.
// Index values are what the data-block enable decoder and address/data muxes expect.
package rtc_ctrl_pkg;

  localparam logic [3:0] IDX_INIT   = 4'b0000;
  localparam logic [3:0] IDX_MS     = 4'b0001;
  localparam logic [3:0] IDX_CMD    = 4'b0010;
  localparam logic [3:0] IDX_FECHA0 = 4'b0011;
  localparam logic [3:0] IDX_FECHA1 = 4'b0100;
  localparam logic [3:0] IDX_FECHA2 = 4'b0101;
  localparam logic [3:0] IDX_HORA0  = 4'b0110;
  localparam logic [3:0] IDX_HORA1  = 4'b0111;
  localparam logic [3:0] IDX_HORA2  = 4'b1000;
  localparam logic [3:0] IDX_IDLE   = 4'b1111;

  localparam logic [3:0] INIT_PRIMERO = IDX_INIT;
  localparam logic [3:0] INIT_ULTIMO  = IDX_MS;
  localparam logic [3:0] RW_PRIMERO   = IDX_CMD;
  localparam logic [3:0] RW_ULTIMO    = IDX_HORA2;

  typedef enum logic [1:0] {REPOSO, EMITE, ESPERA, FIN} estado_t;

  typedef enum logic [1:0] {SEQ_INIT, SEQ_LECTURA, SEQ_ESCRITURA} secuencia_t;

  typedef struct packed {
    logic [3:0] primero;
    logic [3:0] ultimo;
    logic       escribe;
  } cfg_secuencia_t;

  function automatic cfg_secuencia_t cfg_secuencia(input secuencia_t s);
    cfg_secuencia_t c;
    case (s)
      SEQ_INIT:      c = '{primero: INIT_PRIMERO, ultimo: INIT_ULTIMO, escribe: 1'b1};
      SEQ_ESCRITURA: c = '{primero: RW_PRIMERO,   ultimo: RW_ULTIMO,   escribe: 1'b1};
      default:       c = '{primero: RW_PRIMERO,   ultimo: RW_ULTIMO,   escribe: 1'b0};
    endcase
    return c;
  endfunction

endpackage

// File: rtl/secuenciador_registros_rtc_contador_timeout.sv
// Transaction watchdog: cleared by carga, counts while habilita, flags expira at TIMEOUT_CICLOS-1.
// Saturates at the limit so a stalled bus cannot wrap it back into a valid window.
module contador_timeout #(
  parameter int unsigned TIMEOUT_CICLOS = 1024
) (
  input  logic clk,
  input  logic reset,
  input  logic carga,
  input  logic habilita,
  output logic expira
);

  localparam int unsigned W = (TIMEOUT_CICLOS > 2) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [W-1:0] LIMITE = W'(TIMEOUT_CICLOS - 1);

  logic [W-1:0] cuenta_q, cuenta_d;

  always_comb begin
    cuenta_d = cuenta_q;
    if (carga) begin
      cuenta_d = '0;
    end else if (habilita && (cuenta_q != LIMITE)) begin
      cuenta_d = cuenta_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cuenta_q <= '0;
    end else begin
      cuenta_q <= cuenta_d;
    end
  end

  assign expira = (cuenta_q == LIMITE);

endmodule

// File: rtl/secuenciador_registros_rtc.sv
// Steps Selec_Mux_DDw through the init/read/write register lists, one bus transaction per index.
// Request to first inicio_transaccion is 2 cycles; each completion advances the index 2 cycles before the next start.
module secuenciador_registros_rtc
  import rtc_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT_CICLOS = 1024,
  parameter bit          AUTO_INIT      = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start_init,
  input  logic       start_lectura,
  input  logic       start_escritura,
  input  logic       fin_transaccion,
  output logic [3:0] Selec_Mux_DDw,
  output logic       inicio_transaccion,
  output logic       escribe,
  output logic       ocupado,
  output logic       fin_secuencia,
  output logic       error_tiempo
);

  estado_t        estado_q, estado_d;
  logic [3:0]     idx_q, idx_d;
  logic [3:0]     ultimo_q, ultimo_d;
  logic           escribe_q, escribe_d;
  logic           ocupado_q, ocupado_d;
  logic           inicio_q, inicio_d;
  logic           fin_sec_q, fin_sec_d;
  logic           error_q, error_d;
  logic           pendiente_q, pendiente_d;
  logic           primer_q, primer_d;
  logic           carga, habilita, expira, lanzar;
  cfg_secuencia_t cfg;

  contador_timeout #(
    .TIMEOUT_CICLOS(TIMEOUT_CICLOS)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .carga   (carga),
    .habilita(habilita),
    .expira  (expira)
  );

  always_comb begin
    estado_d    = estado_q;
    idx_d       = idx_q;
    ultimo_d    = ultimo_q;
    escribe_d   = escribe_q;
    ocupado_d   = ocupado_q;
    error_d     = error_q;
    pendiente_d = pendiente_q;
    inicio_d    = 1'b0;
    fin_sec_d   = 1'b0;
    primer_d    = 1'b0;
    carga       = 1'b0;
    habilita    = 1'b0;
    lanzar      = 1'b0;
    cfg         = cfg_secuencia(SEQ_LECTURA);

    // Writes arriving mid-sequence collapse into one pending request.
    if ((estado_q != REPOSO) && start_escritura) begin
      pendiente_d = 1'b1;
    end

    case (estado_q)
      REPOSO: begin
        idx_d     = IDX_IDLE;
        ocupado_d = 1'b0;
        if (start_init || (AUTO_INIT && primer_q)) begin
          lanzar = 1'b1;
          cfg    = cfg_secuencia(SEQ_INIT);
          if (start_escritura) pendiente_d = 1'b1;
        end else if (pendiente_q) begin
          lanzar      = 1'b1;
          cfg         = cfg_secuencia(SEQ_ESCRITURA);
          pendiente_d = 1'b0;
        end else if (start_escritura) begin
          lanzar = 1'b1;
          cfg    = cfg_secuencia(SEQ_ESCRITURA);
        end else if (start_lectura) begin
          lanzar = 1'b1;
          cfg    = cfg_secuencia(SEQ_LECTURA);
        end
        if (lanzar) begin
          estado_d  = EMITE;
          idx_d     = cfg.primero;
          ultimo_d  = cfg.ultimo;
          escribe_d = cfg.escribe;
          ocupado_d = 1'b1;
          error_d   = 1'b0;
        end
      end
      EMITE: begin
        carga    = 1'b1;
        inicio_d = 1'b1;
        estado_d = ESPERA;
      end
      ESPERA: begin
        habilita = 1'b1;
        if (fin_transaccion) begin
          if (idx_q == ultimo_q) begin
            estado_d  = FIN;
            fin_sec_d = 1'b1;
          end else begin
            idx_d    = idx_q + 4'd1;
            estado_d = EMITE;
          end
        end else if (expira) begin
          error_d   = 1'b1;
          estado_d  = REPOSO;
          idx_d     = IDX_IDLE;
          ocupado_d = 1'b0;
        end
      end
      FIN: begin
        estado_d  = REPOSO;
        idx_d     = IDX_IDLE;
        ocupado_d = 1'b0;
      end
      default: begin
        estado_d  = REPOSO;
        idx_d     = IDX_IDLE;
        ocupado_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      estado_q    <= REPOSO;
      idx_q       <= IDX_IDLE;
      ultimo_q    <= IDX_IDLE;
      escribe_q   <= 1'b0;
      ocupado_q   <= 1'b0;
      inicio_q    <= 1'b0;
      fin_sec_q   <= 1'b0;
      error_q     <= 1'b0;
      pendiente_q <= 1'b0;
      primer_q    <= 1'b1;
    end else begin
      estado_q    <= estado_d;
      idx_q       <= idx_d;
      ultimo_q    <= ultimo_d;
      escribe_q   <= escribe_d;
      ocupado_q   <= ocupado_d;
      inicio_q    <= inicio_d;
      fin_sec_q   <= fin_sec_d;
      error_q     <= error_d;
      pendiente_q <= pendiente_d;
      primer_q    <= primer_d;
    end
  end

  assign Selec_Mux_DDw      = idx_q;
  assign inicio_transaccion = inicio_q;
  assign escribe            = escribe_q;
  assign ocupado            = ocupado_q;
  assign fin_secuencia      = fin_sec_q;
  assign error_tiempo       = error_q;

endmodule

// File: tb/tb_secuenciador_registros_rtc.sv
// Bench for secuenciador_registros_rtc: sequences are predicted as index ranges plus fixed
// cycle offsets, with a responder answering each start pulse after a random delay.
module tb_secuenciador_registros_rtc;

  localparam int T       = 16;
  localparam int K_INIT  = 0;
  localparam int K_READ  = 1;
  localparam int K_WRITE = 2;
  localparam logic [8:0] M_ALL   = 9'h1ff;
  localparam logic [8:0] M_NOESC = 9'h1f7;
  localparam logic [8:0] V_RESET = 9'h1e0;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start_init = 1'b0;
  logic       start_lectura = 1'b0;
  logic       start_escritura = 1'b0;
  logic       fin_transaccion = 1'b0;
  logic [3:0] sel;
  logic       inicio, escribe, ocupado, fin_secuencia, error_tiempo;
  logic [8:0] obs;
  int         vectors = 0;
  int         miscompares = 0;

  assign obs = {sel, inicio, escribe, ocupado, fin_secuencia, error_tiempo};

  always #5 clk = ~clk;

  secuenciador_registros_rtc #(
    .TIMEOUT_CICLOS(T),
    .AUTO_INIT     (1'b1)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .start_init        (start_init),
    .start_lectura     (start_lectura),
    .start_escritura   (start_escritura),
    .fin_transaccion   (fin_transaccion),
    .Selec_Mux_DDw     (sel),
    .inicio_transaccion(inicio),
    .escribe           (escribe),
    .ocupado           (ocupado),
    .fin_secuencia     (fin_secuencia),
    .error_tiempo      (error_tiempo)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Called on the cycle the first index should appear. Reference: init covers indices 0..1,
  // read/write cover 2..8; every index shows one start pulse the cycle after it appears, and
  // the next index appears the cycle after the completion pulse.
  task automatic run_seq(input int kind, input int wr_at, input int fix_d,
                         input int stop_at, input int rst_at);
    int lo, hi, d;
    logic w;
    logic [8:0] e;
    lo = (kind == K_INIT) ? 0 : 2;
    hi = (kind == K_INIT) ? 1 : 8;
    w  = (kind != K_READ);
    for (int i = lo; i <= hi; i++) begin
      e = {4'(i), 1'b0, w, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL emite idx=%0d: got %b want %b", i, obs, e);
      end
      step();
      e = {4'(i), 1'b1, w, 1'b1, 1'b0, 1'b0};
      vectors++;
      if (obs !== e) begin
        miscompares++;
        $display("FAIL inicio idx=%0d: got %b want %b", i, obs, e);
      end
      if (i == rst_at) begin
        reset = 1'b0;
        step();
        reset = 1'b1;
        vectors++;
        if (obs !== V_RESET) begin
          miscompares++;
          $display("FAIL reset_mid: got %b want %b", obs, V_RESET);
        end
        return;
      end
      if (i == stop_at) begin
        for (int k = 0; k < T - 1; k++) begin
          step();
          e = {4'(i), 1'b0, w, 1'b1, 1'b0, 1'b0};
          vectors++;
          if (obs !== e) begin
            miscompares++;
            $display("FAIL espera_to idx=%0d k=%0d: got %b want %b", i, k, obs, e);
          end
        end
        step();
        e = {4'hf, 1'b0, w, 1'b0, 1'b0, 1'b1};
        vectors++;
        if ((obs & M_NOESC) !== (e & M_NOESC)) begin
          miscompares++;
          $display("FAIL timeout: got %b want %b", obs, e);
        end
        return;
      end
      d = (fix_d > 0) ? fix_d : int'($urandom_range(1, 10));
      for (int k = 0; k < d; k++) begin
        if (i == wr_at && k == 0) start_escritura = 1'b1;
        step();
        start_escritura = 1'b0;
        e = {4'(i), 1'b0, w, 1'b1, 1'b0, 1'b0};
        vectors++;
        if (obs !== e) begin
          miscompares++;
          $display("FAIL espera idx=%0d k=%0d: got %b want %b", i, k, obs, e);
        end
      end
      fin_transaccion = 1'b1;
      step();
      fin_transaccion = 1'b0;
    end
    e = {4'(hi), 1'b0, w, 1'b1, 1'b1, 1'b0};
    vectors++;
    if (obs !== e) begin
      miscompares++;
      $display("FAIL fin_sec: got %b want %b", obs, e);
    end
    step();
    e = {4'hf, 1'b0, w, 1'b0, 1'b0, 1'b0};
    vectors++;
    if ((obs & M_NOESC) !== (e & M_NOESC)) begin
      miscompares++;
      $display("FAIL reposo: got %b want %b", obs, e);
    end
  endtask

  // Idle cycles with stray completion pulses, which must not disturb anything.
  task automatic test_idle(input int n, input logic err);
    logic [8:0] e;
    e = {4'hf, 1'b0, 1'b0, 1'b0, 1'b0, err};
    for (int k = 0; k < n; k++) begin
      fin_transaccion = 1'($urandom_range(0, 1));
      step();
      vectors++;
      if ((obs & M_NOESC) !== (e & M_NOESC)) begin
        miscompares++;
        $display("FAIL idle k=%0d: got %b want %b", k, obs, e);
      end
    end
    fin_transaccion = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      vectors++;
      if (obs !== V_RESET) begin
        miscompares++;
        $display("FAIL reset k=%0d: got %b want %b", k, obs, V_RESET);
      end
    end
  endtask

  task automatic test_auto_init();
    reset = 1'b1;
    vectors++;
    if (obs !== V_RESET) begin
      miscompares++;
      $display("FAIL release: got %b want %b", obs, V_RESET);
    end
    step();
    run_seq(K_INIT, -1, 5, -1, -1);
    test_idle(4, 1'b0);
  endtask

  task automatic test_read();
    start_lectura = 1'b1;
    step();
    start_lectura = 1'b0;
    run_seq(K_READ, -1, 3, -1, -1);
    test_idle(3, 1'b0);
  endtask

  task automatic test_random_requests();
    int kind;
    for (int n = 0; n < 4; n++) begin
      kind = int'($urandom_range(0, 2));
      start_init      = (kind == K_INIT);
      start_lectura   = (kind == K_READ);
      start_escritura = (kind == K_WRITE);
      step();
      start_init = 1'b0; start_lectura = 1'b0; start_escritura = 1'b0;
      run_seq(kind, -1, 0, -1, -1);
      test_idle(int'($urandom_range(1, 3)), 1'b0);
    end
  endtask

  task automatic test_write_during_read();
    start_lectura = 1'b1;
    step();
    start_lectura = 1'b0;
    run_seq(K_READ, 5, 0, -1, -1);
    step();
    run_seq(K_WRITE, -1, 0, -1, -1);
    test_idle(4, 1'b0);
  endtask

  task automatic test_timeout();
    start_lectura = 1'b1;
    step();
    start_lectura = 1'b0;
    run_seq(K_READ, -1, T - 1, 4, -1);
    test_idle(3, 1'b1);
    start_lectura = 1'b1;
    step();
    start_lectura = 1'b0;
    run_seq(K_READ, -1, 0, -1, -1);
    test_idle(2, 1'b0);
  endtask

  task automatic test_back_to_back();
    start_init = 1'b1; start_escritura = 1'b1; start_lectura = 1'b1;
    step();
    start_init = 1'b0; start_escritura = 1'b0; start_lectura = 1'b0;
    run_seq(K_INIT, -1, 0, -1, -1);
    step();
    run_seq(K_WRITE, -1, 0, -1, -1);
    test_idle(6, 1'b0);
  endtask

  task automatic test_reset_mid();
    start_lectura = 1'b1;
    step();
    start_lectura = 1'b0;
    run_seq(K_READ, 3, 0, -1, 7);
    step();
    run_seq(K_INIT, -1, 0, -1, -1);
    test_idle(6, 1'b0);
  endtask

  initial begin
    test_reset();
    test_auto_init();
    test_read();
    test_random_requests();
    test_write_during_read();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/secuenciador_registros_rtc.md
Name: secuenciador_registros_rtc

Overview:
- Control-path sequencer that drives Selec_Mux_DDw, the 4-bit register index consumed by the data-block enable decoder and the address/data muxes.
- Runs three fixed transaction sequences against the RTC bus-timing generator:
  - init: configure the RTC after reset.
  - read: periodic refresh of date/time.
  - write: user programming of date/time.
- Issues one transaction start pulse per index and advances the index only on the generator's completion pulse.
- A timeout guards every transaction.

Parameters:
- TIMEOUT_CICLOS, 1024: max cycles to wait for fin_transaccion before aborting the sequence.
- AUTO_INIT, 1: 1 = init sequence is requested automatically on the first cycle after reset is released.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-low reset.
- start_init  input  1  init sequence request, single-cycle pulse.
- start_lectura  input  1  read sequence request, periodic single-cycle tick.
- start_escritura  input  1  write sequence request, single-cycle pulse.
- fin_transaccion  input  1  completion pulse from the bus-timing generator, one cycle.
- Selec_Mux_DDw  output  4  current register index.
- inicio_transaccion  output  1  one-cycle start pulse to the bus-timing generator.
- escribe  output  1  1 = current transaction is a write, 0 = a read.
- ocupado  output  1  high while any sequence is active.
- fin_secuencia  output  1  one-cycle pulse when a sequence completes successfully.
- error_tiempo  output  1  sticky timeout flag.

Behaviour:
- Interface:
  - Single clock, clk.
  - Reset is synchronous and active-low: sampled on the rising edge of clk, active when reset = 0.
  - All outputs are registered.
- Reset values:
  - Selec_Mux_DDw = 4'b1111 (IDLE index; the decoder drives all enables to 0).
  - inicio_transaccion = 0, escribe = 0, ocupado = 0, fin_secuencia = 0, error_tiempo = 0.
  - Pending-write flag cleared; FSM in REPOSO.
- Sequences (index lists):
  - INIT: 0000, 0001; escribe = 1.
  - READ: 0010 (command/address transfer), then 0011, 0100, 0101, 0110, 0111, 1000; escribe = 0.
  - WRITE: 0010, 0011 … 1000; escribe = 1.
- FSM states: REPOSO, EMITE, ESPERA, FIN.
- REPOSO:
  - Selec_Mux_DDw = 1111, ocupado = 0.
  - On a request, the next cycle enters EMITE with:
    - Selec_Mux_DDw = first index of the sequence;
    - escribe set per the sequence;
    - ocupado = 1;
    - error_tiempo cleared.
- Request priority in REPOSO: init > pending write > start_escritura > start_lectura.
  - Simultaneous requests: only the highest is served. A lower-priority write is latched as pending; a lower-priority read is dropped.
- EMITE:
  - inicio_transaccion = 1 for exactly one cycle.
  - Timeout counter loads 0.
  - Next state is ESPERA.
  - Latency: request pulse to first inicio_transaccion = 2 cycles.
- ESPERA:
  - Counter increments each cycle.
  - If fin_transaccion = 1 and the index is not the last: increment the index, then EMITE.
  - If fin_transaccion = 1 and the index is the last: go to FIN.
  - If the counter reaches TIMEOUT_CICLOS-1 without fin_transaccion: set error_tiempo = 1, go to REPOSO (Selec = 1111, ocupado = 0), no fin_secuencia.
  - fin_transaccion and timeout on the same cycle: fin_transaccion wins.
- fin_transaccion outside ESPERA is ignored.
- FIN:
  - fin_secuencia = 1 for one cycle.
  - Next state is REPOSO.
  - If a write is pending, it is served from REPOSO on the following cycle.
- While ocupado = 1:
  - start_lectura is ignored.
  - start_escritura sets the pending flag; a single flag, further pulses merge.
  - start_init is ignored.
- Selec_Mux_DDw is stable from EMITE through the end of ESPERA for each index and never passes through an index outside the active sequence.
- Reset asserted mid-sequence: next cycle all outputs hold their reset values, pending flag is cleared, no fin_secuencia.
- AUTO_INIT = 1: the first cycle with reset = 1 behaves as a start_init pulse.

Decomposition:
- Shared package (rtc_ctrl_pkg):
  - index constants IDX_INIT, IDX_MS, IDX_CMD, IDX_FECHA0..2, IDX_HORA0..2, IDX_IDLE = 4'b1111;
  - state encoding;
  - sequence first/last index constants.
- One natural sub-module: contador_timeout.
  - Inputs: clk, reset, carga, habilita.
  - Output: expira.
  - Width $clog2(TIMEOUT_CICLOS).

Test Plan:
- AUTO_INIT = 1, release reset, answer each inicio_transaccion with fin_transaccion after 5 cycles:
  - Selec goes 1111 → 0000 → 0001 → 1111;
  - escribe = 1;
  - exactly two inicio pulses;
  - one fin_secuencia.
- start_lectura from idle, fin_transaccion after 3 cycles each:
  - Selec steps 0010, 0011 … 1000;
  - 7 inicio pulses, escribe = 0;
  - fin_secuencia 1 cycle after the last fin.
- start_escritura during a read at index 0101:
  - read completes;
  - write starts 2 cycles after fin_secuencia, escribe = 1, Selec = 0010.
- Withhold fin_transaccion at index 0100 (TIMEOUT_CICLOS = 16):
  - error_tiempo = 1 on cycle 16 of ESPERA;
  - Selec = 1111, ocupado = 0, no fin_secuencia;
  - next start_lectura clears error_tiempo.
- start_init + start_escritura + start_lectura on the same cycle:
  - init served first;
  - write served next;
  - read dropped.
- reset = 0 for 1 cycle while at index 0111:
  - next cycle all outputs at reset values, pending write cleared.
